// File: rtl/bcd_down_timer.sv
// bcd_down_timer: loadable multi-digit BCD countdown timer with pause/hold,
// a one-cycle terminal-count pulse and a sticky invalid-load flag.
module bcd_down_timer #(
   parameter int DIGITS = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   input  logic                start,
   input  logic                pause,
   output logic [4*DIGITS-1:0] count,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam int W = 4 * DIGITS;
   localparam logic [W-1:0] ZERO = {W{1'b0}};
   localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t         state_r, state_s;
   logic [W-1:0]   count_r, count_s;
   logic           busy_r, busy_s;
   logic           done_r, done_s;
   logic           err_r, err_s;

   // True when every nibble holds a decimal digit.
   function automatic logic bcd_valid(input logic [W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) begin
            ok = 1'b0;
         end else begin
            ok = ok;
         end
      end
      return ok;
   endfunction

   // BCD minus one: a digit borrows (0 -> 9) only while every lower digit is 0.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end else begin
            r[4*i +: 4] = v[4*i +: 4];
         end
      end
      return r;
   endfunction

   // State register and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
         count_r <= ZERO;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         count_r <= count_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         err_r   <= err_s;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_s = state_r;
      count_s = count_r;
      busy_s  = 1'b0;
      done_s  = 1'b0;
      err_s   = err_r;

      case (state_r)
         S_IDLE, S_DONE: begin
            if (load) begin
               if (bcd_valid(load_val)) begin
                  count_s = load_val;
                  err_s   = 1'b0;
                  state_s = S_IDLE;
               end else begin
                  err_s   = 1'b1;
               end
            end else if (start) begin
               if (count_r != ZERO) begin
                  state_s = S_RUN;
               end else begin
                  state_s = S_DONE;
                  done_s  = 1'b1;
               end
            end else begin
               state_s = state_r;
            end
         end
         S_RUN: begin
            if (pause) begin
               state_s = S_HOLD;
            end else if ((count_r == ONE) || (count_r == ZERO)) begin
               // Terminal edge: land exactly on zero, never wrap.
               count_s = ZERO;
               state_s = S_DONE;
               done_s  = 1'b1;
            end else begin
               count_s = bcd_dec(count_r);
            end
         end
         S_HOLD: begin
            if (pause) begin
               state_s = S_HOLD;
            end else begin
               state_s = S_RUN;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase

      if ((state_s == S_RUN) || (state_s == S_HOLD)) begin
         busy_s = 1'b1;
      end else begin
         busy_s = 1'b0;
      end
   end

   assign count = count_r;
   assign busy  = busy_r;
   assign done  = done_r;
   assign err   = err_r;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer: vector table, directed corner
// sequences and randomized traffic against an integer-arithmetic model.
module tb_bcd_down_timer;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [7:0]  load_val;
   logic        start;
   logic        pause;
   logic [7:0]  count;
   logic        busy, done, err;

   logic        load3;
   logic [11:0] load_val3;
   logic        start3;
   logic        pause3;
   logic [11:0] count3;
   logic        busy3, done3, err3;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bcd_down_timer #(.DIGITS(2)) u_dut (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val),
      .start(start), .pause(pause),
      .count(count), .busy(busy), .done(done), .err(err)
   );

   bcd_down_timer #(.DIGITS(3)) u_dut3 (
      .clk(clk), .rst(rst), .load(load3), .load_val(load_val3),
      .start(start3), .pause(pause3),
      .count(count3), .busy(busy3), .done(done3), .err(err3)
   );

   typedef struct {
      logic       ld;
      logic [7:0] lv;
      logic       st;
      logic       pa;
      logic [7:0] c;
      logic       b;
      logic       d;
      logic       e;
   } vec_t;

   vec_t vecs[20];

   // Reference model: decimal value as a plain integer plus run/hold flags.
   int m_val;
   bit m_run, m_hold, m_done, m_err;

   function automatic bit is_bcd(input logic [7:0] v);
      return ((v / 16) <= 9) && ((v % 16) <= 9);
   endfunction

   function automatic int bcd2int(input logic [7:0] v);
      return (v / 16) * 10 + (v % 16);
   endfunction

   function automatic logic [7:0] int2bcd(input int n);
      return 8'((n / 10) * 16 + (n % 10));
   endfunction

   task automatic model_reset();
      m_val = 0; m_run = 1'b0; m_hold = 1'b0; m_done = 1'b0; m_err = 1'b0;
   endtask

   task automatic model_step(input logic ld, input logic [7:0] lv,
                             input logic st, input logic pa);
      m_done = 1'b0;
      if (!m_run && !m_hold) begin
         if (ld) begin
            if (is_bcd(lv)) begin
               m_val = bcd2int(lv);
               m_err = 1'b0;
            end else begin
               m_err = 1'b1;
            end
         end else if (st) begin
            if (m_val != 0) m_run = 1'b1;
            else            m_done = 1'b1;
         end
      end else if (m_hold) begin
         if (!pa) begin
            m_hold = 1'b0;
            m_run  = 1'b1;
         end
      end else begin
         if (pa) begin
            m_run  = 1'b0;
            m_hold = 1'b1;
         end else begin
            m_val = m_val - 1;
            if (m_val == 0) begin
               m_run  = 1'b0;
               m_done = 1'b1;
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      check(name, {4'h0, act}, {4'h0, exp});
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      check(name, {11'd0, act}, {11'd0, exp});
   endtask

   task automatic step(input logic ld, input logic [7:0] lv, input logic st, input logic pa);
      load = ld; load_val = lv; start = st; pause = pa;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      load = 1'b0; load_val = 8'h00; start = 1'b0; pause = 1'b0;
      load3 = 1'b0; load_val3 = 12'h000; start3 = 1'b0; pause3 = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      rst = 1'b1;
      load = 1'b0; load_val = 8'h00; start = 1'b0; pause = 1'b0;
      load3 = 1'b0; load_val3 = 12'h000; start3 = 1'b0; pause3 = 1'b0;
      #1;
      chk8("reset.count", count, 8'h00);
      chk1("reset.busy", busy, 1'b0);
      chk1("reset.done", done, 1'b0);
      chk1("reset.err", err, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      //            ld    lv     st    pa    count  busy  done  err
      vecs[0]  = '{1'b1, 8'h3A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, 8'h07, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 8'h05, 1'b1, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 8'h42, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{1'b1, 8'h3A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[17] = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
      vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0};
      vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h09, 1'b1, 1'b0, 1'b0};

      for (int i = 0; i < 20; i++) begin
         step(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].pa);
         chk8($sformatf("vec%0d.count", i), count, vecs[i].c);
         chk1($sformatf("vec%0d.busy", i), busy, vecs[i].b);
         chk1($sformatf("vec%0d.done", i), done, vecs[i].d);
         chk1($sformatf("vec%0d.err", i), err, vecs[i].e);
      end

      // Full run from 25 down to 00.
      do_reset();
      step(1'b1, 8'h25, 1'b0, 1'b0);
      chk8("run25.load", count, 8'h25);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk8("run25.start.count", count, 8'h25);
      chk1("run25.start.busy", busy, 1'b1);
      for (int n = 24; n >= 0; n--) begin
         step(1'b0, 8'h00, 1'b0, 1'b0);
         chk8($sformatf("run25.count@%0d", n), count, int2bcd(n));
         chk1($sformatf("run25.busy@%0d", n), busy, n != 0);
         chk1($sformatf("run25.done@%0d", n), done, n == 0);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk1("run25.done_after", done, 1'b0);
      chk8("run25.hold_zero", count, 8'h00);

      // Two-digit borrow 99 -> 89, and three-digit borrow 100 -> 099.
      step(1'b1, 8'h99, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      for (int n = 98; n >= 89; n--) begin
         step(1'b0, 8'h00, 1'b0, 1'b0);
         chk8($sformatf("run99.count@%0d", n), count, int2bcd(n));
      end
      load3 = 1'b1; load_val3 = 12'h100;
      step(1'b0, 8'h00, 1'b0, 1'b0);
      load3 = 1'b0; start3 = 1'b1;
      step(1'b0, 8'h00, 1'b0, 1'b0);
      start3 = 1'b0;
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check("d3.borrow", count3, 12'h099);
      chk1("d3.busy", busy3, 1'b1);

      // Asynchronous reset mid-count: outputs clear before the next edge.
      do_reset();
      step(1'b1, 8'h37, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk8("arst.pre", count, 8'h37);
      #2;
      rst = 1'b1;
      #1;
      chk8("arst.count", count, 8'h00);
      chk1("arst.busy", busy, 1'b0);
      chk1("arst.done", done, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 8'h00, 1'b0, 1'b0);
         chk1($sformatf("arst.no_done%0d", k), done, 1'b0);
         chk8($sformatf("arst.count%0d", k), count, 8'h00);
      end

      // Randomized traffic against the reference model.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         logic       ld, st, pa;
         logic [7:0] lv;
         ld = ($urandom_range(0, 9) == 0);
         st = ($urandom_range(0, 4) == 0);
         pa = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 3) == 0) lv = 8'($urandom_range(0, 255));
         else                           lv = int2bcd($urandom_range(0, 40));
         step(ld, lv, st, pa);
         model_step(ld, lv, st, pa);
         chk8($sformatf("rnd%0d.count", c), count, int2bcd(m_val));
         chk1($sformatf("rnd%0d.busy", c), busy, m_run | m_hold);
         chk1($sformatf("rnd%0d.done", c), done, m_done);
         chk1($sformatf("rnd%0d.err", c), err, m_err);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Synchronous multi-digit BCD down-counter (countdown timer).
- It is the counting-down counterpart of the team's synchronous 4-bit BCD up-counter: it is loaded with a decimal value, decrements once per clock while running, and flags terminal count.
- Used as a programmable decimal delay/timeout source next to the up-counter in the same single-clock domain.

Parameters:
- DIGITS, 2, number of cascaded BCD digits; count width = 4*DIGITS.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous reset, active-high.
- load  input  1  load request, sampled on clk rising edge.
- load_val  input  4*DIGITS  BCD value to load; digit 0 is the least-significant nibble.
- start  input  1  start countdown, sampled on clk.
- pause  input  1  level; freezes the count while high.
- count  output  4*DIGITS  current BCD value, registered.
- busy  output  1  high in RUN or HOLD.
- done  output  1  one-cycle pulse at terminal count.
- err  output  1  sticky invalid-load flag.

Behaviour:
- Reset: rst high forces the following immediately, with no clock edge needed: state=IDLE, count=0, busy=0, done=0, err=0.
- Reset asserted mid-count aborts the count. No done pulse is produced.
- States: IDLE, RUN, HOLD, DONE. All outputs are registered.
- load is accepted only in IDLE or DONE:
  - If every nibble of load_val is <= 9: count <= load_val and err <= 0 on that edge; state becomes IDLE.
  - If any nibble is > 9: count is unchanged, err <= 1, state is unchanged.
  - err stays high until the next valid load or reset.
  - load in RUN or HOLD is ignored; err is unchanged.
- load and start high on the same edge: load wins and start is ignored.
- start in IDLE or DONE (load low):
  - count != 0: state <= RUN and busy <= 1. The first decrement happens on the following edge.
  - count == 0: state <= DONE and done <= 1 on that edge. No decrement occurs and there is no wrap.
- RUN, pause low: each edge performs count <= count - 1 in BCD.
  - Digit 0 decrements.
  - Digit i borrows (0 -> 9) only when digit i is 0 and all lower digits are 0.
  - The count never leaves the valid BCD range.
- RUN, pause high: state <= HOLD and no decrement on that edge.
- HOLD: the count is frozen and busy stays 1. When pause goes low: state <= RUN and decrementing resumes on the next edge.
- Terminal count: on the edge where count goes from 0...01 to 0: state <= DONE, done <= 1 for exactly one cycle, busy <= 0.
- DONE: the count holds at 0 and done returns to 0 on the next edge. A new load or start is accepted as described above.
- Latency: N loaded (decimal, N > 0) reaches 0 exactly N unpaused RUN edges after the start edge +1.
- start in RUN or HOLD is ignored.

Test Plan:
- Async reset: count at 8'h37 in RUN, raise rst between edges -> count=8'h00, busy=0, done=0 before the next edge; no done pulse follows.
- Full run: load 8'h25, start, pause=0 -> count steps 25,24,...,20,19,...,01,00 on consecutive edges. done is high for exactly the one cycle in which count first reads 00; busy is 1 from the start edge +1 until count=00.
- Borrow/wrap: load 8'h10 then start -> next value 8'h09. With DIGITS=3, load 12'h100 -> 12'h099. With DIGITS=2, load 8'h99 -> 8'h98 -> ... (check 8'h90 -> 8'h89).
- Invalid load and priority:
  - load 8'h3A -> err=1 and count unchanged.
  - load 8'h07 -> err=0, count=8'h07.
  - load+start together with 8'h05 -> count=05, state IDLE, busy=0.
- Pause: load 8'h05, start, hold pause high once count=03 for 3 cycles -> count stays 03 with busy=1. Release pause -> 02, 01, 00 on the next three edges, then the done pulse.
- Zero/ignored inputs:
  - start with count=00 -> done pulses the next cycle; count stays 00 (never 99).
  - load 8'h42 during RUN -> ignored; the countdown continues unaffected.
